// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, move encodings, FSM states and wall maps for grid_mover
package grid_pkg;
  localparam int GRID_W    = 20;
  localparam int GRID_H    = 15;
  localparam int COORD_W   = 5;
  localparam int NUM_MAPS  = 4;
  localparam int MAP_SEL_W = 2;
  localparam int ROW_IW    = $clog2(GRID_H);

  localparam logic [2:0] DIR_RIGHT = 3'b100;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_CHECK} state_t;
  typedef logic [GRID_W-1:0] row_t;

  // Rows are drawn left-to-right as seen on screen; lr() flips them so bit x is cell x.
  function automatic row_t lr(input row_t s);
    row_t r;
    for (int i = 0; i < GRID_W; i++) r[i] = s[GRID_W-1-i];
    return r;
  endfunction

  localparam row_t MAP_DATA [NUM_MAPS][GRID_H] = '{
    '{
      lr(20'b11111111011111111111),
      lr(20'b10000001000100000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10001110000011100001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10110000000001100001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b11000000000000000001),
      lr(20'b11111111111110111111)
    },
    '{
      lr(20'b11111111011111111111),
      lr(20'b10000000010000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10011111000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000011111001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b11111111111111111101)
    },
    '{
      lr(20'b11111111011111111111),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b11111111011111111111),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10111111111111111111)
    },
    '{
      lr(20'b11111111011111111111),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10101010101010101001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10010101010101010101),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b10000000000000000001),
      lr(20'b11111111110111111111)
    }
  };
endpackage

// File: rtl/map_rom.sv
// rtl/map_rom.sv - registered wall ROM, address {map, row}, one cycle of read latency
module map_rom
  import grid_pkg::*;
(
  input  logic                 i_clk,
  input  logic [MAP_SEL_W-1:0] i_map,
  input  logic [ROW_IW-1:0]    i_row,
  output logic [GRID_W-1:0]    o_data
);
  logic [GRID_W-1:0] r_data;

  always_ff @(posedge i_clk) begin
    r_data <= MAP_DATA[i_map][i_row];
  end

  assign o_data = r_data;
endmodule

// File: rtl/grid_mover.sv
// rtl/grid_mover.sv - player grid position owner: one move at a time, ROM wall check, step/exit reporting
module grid_mover
  import grid_pkg::*;
#(
  parameter int GRID_W    = 20,
  parameter int GRID_H    = 15,
  parameter int COORD_W   = 5,
  parameter int NUM_MAPS  = 4,
  parameter int MAP_SEL_W = 2,
  parameter int START_X   = 8,
  parameter int START_Y   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [MAP_SEL_W-1:0] i_map_sel,
  input  logic                 i_map_load,
  input  logic                 i_move_valid,
  output logic                 o_move_ready,
  input  logic [2:0]           i_move_dir,
  output logic [COORD_W-1:0]   o_pos_x,
  output logic [COORD_W-1:0]   o_pos_y,
  output logic                 o_move_done,
  output logic                 o_blocked,
  output logic                 o_exit_hit,
  output logic [CNT_W-1:0]     o_step_count
);
  localparam logic [COORD_W:0]   X_LIM     = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]   Y_LIM     = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W:0]   C_ONE     = (COORD_W+1)'(1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(GRID_H-1);
  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [MAP_SEL_W:0] MAP_LIM   = (MAP_SEL_W+1)'(NUM_MAPS);

  state_t                 r_state, w_next;
  logic [MAP_SEL_W-1:0]   r_map, w_map_clamped;
  logic [COORD_W-1:0]     r_pos_x, r_pos_y;
  logic [COORD_W-1:0]     r_tgt_x, r_tgt_y;
  logic                   r_noop, r_oob;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [COORD_W:0]       w_cur_x, w_cur_y, w_tgt_x, w_tgt_y;
  logic                   w_noop, w_oob, w_accept;
  logic [ROW_IW-1:0]      w_rom_row;
  logic [GRID_W-1:0]      w_rom_data;
  logic                   w_wall, w_blocked, w_check, w_commit;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_map_load) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_move_valid) w_next = ST_LOOKUP;
        ST_LOOKUP: w_next = ST_CHECK;
        ST_CHECK:  w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Target is one bit wider so that stepping off either edge lands out of range.
  always_comb begin
    w_cur_x = {1'b0, r_pos_x};
    w_cur_y = {1'b0, r_pos_y};
    w_tgt_x = w_cur_x;
    w_tgt_y = w_cur_y;
    w_noop  = 1'b0;
    case (i_move_dir)
      DIR_RIGHT: w_tgt_x = w_cur_x + C_ONE;
      DIR_LEFT:  w_tgt_x = w_cur_x - C_ONE;
      DIR_UP:    w_tgt_y = w_cur_y - C_ONE;
      DIR_DOWN:  w_tgt_y = w_cur_y + C_ONE;
      default:   w_noop  = 1'b1;
    endcase
  end

  assign w_oob         = (w_tgt_x >= X_LIM) || (w_tgt_y >= Y_LIM);
  assign w_accept      = (r_state == ST_IDLE) && i_move_valid && !i_map_load;
  assign w_map_clamped = ({1'b0, i_map_sel} < MAP_LIM) ? i_map_sel : '0;

  assign w_rom_row = r_oob ? '0 : r_tgt_y[ROW_IW-1:0];

  map_rom u_map_rom (
    .i_clk  (i_clk),
    .i_map  (r_map),
    .i_row  (w_rom_row),
    .o_data (w_rom_data)
  );

  assign w_wall     = w_rom_data[r_tgt_x];
  assign w_check    = (r_state == ST_CHECK);
  assign w_blocked  = r_oob || (!r_noop && w_wall);
  assign w_commit   = w_check && !w_blocked && !r_noop;
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_map   <= '0;
      r_pos_x <= START_X_C;
      r_pos_y <= START_Y_C;
      r_cnt   <= '0;
      r_tgt_x <= '0;
      r_tgt_y <= '0;
      r_noop  <= 1'b0;
      r_oob   <= 1'b0;
    end else if (i_map_load) begin
      r_map   <= w_map_clamped;
      r_pos_x <= START_X_C;
      r_pos_y <= START_Y_C;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_tgt_x <= w_tgt_x[COORD_W-1:0];
        r_tgt_y <= w_tgt_y[COORD_W-1:0];
        r_noop  <= w_noop;
        r_oob   <= w_oob;
      end
      if (w_commit) begin
        r_pos_x <= r_tgt_x;
        r_pos_y <= r_tgt_y;
        r_cnt   <= w_cnt_next;
      end
    end
  end

  // Outputs look ahead in CHECK so the new position is visible alongside move_done.
  assign o_move_ready = (r_state == ST_IDLE);
  assign o_move_done  = w_check;
  assign o_blocked    = w_check && w_blocked;
  assign o_exit_hit   = w_commit && (r_tgt_y == Y_LAST);
  assign o_pos_x      = w_commit ? r_tgt_x : r_pos_x;
  assign o_pos_y      = w_commit ? r_tgt_y : r_pos_y;
  assign o_step_count = w_commit ? w_cnt_next : r_cnt;
endmodule
